// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: word size, NOP encoding and the skid-stage
// state encoding.
package pipe_pkg;

    localparam int WORD_SIZE = 16;

    // Instruction word presented whenever a stage holds a bubble.
    localparam logic [WORD_SIZE-1:0] NOP_INSTR = 16'hF000;

    // Skid-stage states; the encoding doubles as the entry count.
    typedef logic [1:0] skid_state_t;
    localparam skid_state_t ST_EMPTY = 2'd0;
    localparam skid_state_t ST_ONE   = 2'd1;
    localparam skid_state_t ST_FULL  = 2'd2;

endpackage

// File: rtl/pipe_entry.sv
// One pipeline storage slot (payload + control bundle). It can load a new
// value, clear to the NOP bubble, or hold its current value.
module pipe_entry
    import pipe_pkg::*;
#(
    parameter int                 DATA_W   = WORD_SIZE,
    parameter int                 CTRL_W   = 12,
    parameter logic [DATA_W-1:0]  NOP_DATA = DATA_W'(NOP_INSTR)
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] data_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    output logic [DATA_W-1:0] data_q,
    output logic [CTRL_W-1:0] ctrl_q
);

    // Clear wins over load so that reset and flush always leave a clean bubble.
    always_ff @(posedge clk) begin
        if (clear) begin
            data_q <= NOP_DATA;
            ctrl_q <= '0;
        end else if (load) begin
            data_q <= data_in;
            ctrl_q <= ctrl_in;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry skid-buffered pipeline stage. MAIN drives the outputs and SKID
// absorbs one entry while the downstream stalls, so in_ready stays registered.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                 DATA_W   = 16,
    parameter int                 CTRL_W   = 12,
    parameter logic [DATA_W-1:0]  NOP_DATA = DATA_W'(NOP_INSTR)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    // Handshake: an entry moves on a rising edge when valid && ready on that
    // side; valid never depends on ready, and both readys/valids come only
    // from the state register (no combinational path across the stage).

    skid_state_t       state;
    skid_state_t       state_next;
    logic              push;
    logic              pop;
    logic              clear;
    logic              main_load;
    logic              main_from_skid;
    logic              skid_load;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] main_data_in;
    logic [CTRL_W-1:0] main_ctrl_in;

    assign in_ready  = (state != ST_FULL);
    assign out_valid = (state != ST_EMPTY);
    assign occupancy = state;

    assign push  = in_valid && in_ready;
    assign pop   = out_valid && out_ready;
    assign clear = !reset_n || flush;

    always_comb begin
        state_next     = state;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (push) begin
                    state_next = ST_ONE;
                    main_load  = 1'b1;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    main_load = 1'b1;
                end else if (pop) begin
                    state_next = ST_EMPTY;
                end else if (push) begin
                    state_next = ST_FULL;
                    skid_load  = 1'b1;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    state_next     = ST_ONE;
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    assign main_data_in = main_from_skid ? skid_data : in_data;
    assign main_ctrl_in = main_from_skid ? skid_ctrl : in_ctrl;

    pipe_entry #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .NOP_DATA (NOP_DATA)
    ) u_main (
        .clk     (clk),
        .clear   (clear),
        .load    (main_load),
        .data_in (main_data_in),
        .ctrl_in (main_ctrl_in),
        .data_q  (main_data),
        .ctrl_q  (main_ctrl)
    );

    pipe_entry #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .NOP_DATA (NOP_DATA)
    ) u_skid (
        .clk     (clk),
        .clear   (clear),
        .load    (skid_load),
        .data_in (in_data),
        .ctrl_in (in_ctrl),
        .data_q  (skid_data),
        .ctrl_q  (skid_ctrl)
    );

    // A stale MAIN value after draining must never leak a write or halt.
    assign out_data = out_valid ? main_data : NOP_DATA;
    assign out_ctrl = out_valid ? main_ctrl : '0;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: a queue model of the held entries is
// compared every cycle, plus literal checks at the interesting points.
module tb_pipe_stage_skid;

    localparam int DATA_W = 16;
    localparam int CTRL_W = 12;
    localparam int W      = DATA_W + CTRL_W;

    logic              clk;
    logic              reset_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        occupancy;

    int checks;
    int errors;
    bit model_ok;
    bit seen_b3;
    int max_occ;

    // Expected contents, head first: {ctrl, data}.
    logic [W-1:0] exp_q[$];

    pipe_stage_skid #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .NOP_DATA (16'hF000)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .occupancy (occupancy)
    );

    // Clock and reset-time defaults
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Driver: present one cycle of inputs, let one rising edge consume them.
    task automatic step(input logic rst_v, input logic v, input logic [DATA_W-1:0] d,
                        input logic [CTRL_W-1:0] c, input logic ordy, input logic fl);
        reset_n   = rst_v;
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0000, 12'h000, 1'b1, 1'b0);
    endtask

    // Model: a FIFO of at most two entries; reset and flush empty it.
    always @(posedge clk) begin
        int  n;
        bit  m_push;
        bit  m_pop;
        if (!reset_n) begin
            exp_q.delete();
            model_ok = 1'b1;
        end else if (flush) begin
            exp_q.delete();
        end else if (model_ok) begin
            n      = exp_q.size();
            m_pop  = (n > 0) && out_ready;
            m_push = in_valid && (n < 2);
            if (m_pop) void'(exp_q.pop_front());
            if (m_push) exp_q.push_back({in_ctrl, in_data});
        end
    end

    // Scoreboard compare, away from the active edge.
    always @(negedge clk) begin
        logic [DATA_W-1:0] e_data;
        logic [CTRL_W-1:0] e_ctrl;
        if (model_ok) begin
            if (exp_q.size() > 0) begin
                e_data = exp_q[0][DATA_W-1:0];
                e_ctrl = exp_q[0][W-1:DATA_W];
            end else begin
                e_data = 16'hF000;
                e_ctrl = '0;
            end
            check("occupancy", 32'(occupancy), 32'(exp_q.size()));
            check("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
            check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
            check("out_data", 32'(out_data), 32'(e_data));
            check("out_ctrl", 32'(out_ctrl), 32'(e_ctrl));
            if (out_valid && out_data == 16'h00B3) seen_b3 = 1'b1;
            if (32'(occupancy) > max_occ) max_occ = 32'(occupancy);
        end
    end

    initial begin
        checks   = 0;
        errors   = 0;
        model_ok = 1'b0;
        seen_b3  = 1'b0;
        max_occ  = 0;

        // Reset then idle
        step(1'b0, 1'b0, 16'h0000, 12'h000, 1'b0, 1'b0);
        check("rst_occ", 32'(occupancy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h0000_F000);
        check("rst_out_ctrl", 32'(out_ctrl), 32'd0);
        idle(2);

        // Streaming with one-cycle latency
        max_occ = 0;
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b1, 16'(i), 12'(12'h100 + i), 1'b1, 1'b0);
            check("stream_data", 32'(out_data), 32'(i));
            check("stream_ctrl", 32'(out_ctrl), 32'(12'h100 + i));
        end
        idle(2);
        check("stream_max_occ", 32'(max_occ), 32'd1);

        // Backpressure fills SKID
        step(1'b1, 1'b1, 16'h00A1, 12'h0A1, 1'b0, 1'b0);
        check("bp_occ1", 32'(occupancy), 32'd1);
        step(1'b1, 1'b1, 16'h00A2, 12'h0A2, 1'b0, 1'b0);
        check("bp_occ2", 32'(occupancy), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_head", 32'(out_data), 32'h0000_00A1);
        step(1'b1, 1'b1, 16'h00AF, 12'h0AF, 1'b0, 1'b0);
        check("bp_hold_head", 32'(out_data), 32'h0000_00A1);
        step(1'b1, 1'b0, 16'h0000, 12'h000, 1'b1, 1'b0);
        check("bp_second", 32'(out_data), 32'h0000_00A2);
        check("bp_occ_after", 32'(occupancy), 32'd1);
        idle(2);

        // Flush while FULL with a pending push
        step(1'b1, 1'b1, 16'h00B1, 12'h0B1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'h00B2, 12'h0B2, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'h00B3, 12'hFFF, 1'b0, 1'b1);
        check("flush_occ", 32'(occupancy), 32'd0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_out_ctrl", 32'(out_ctrl), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        idle(2);

        // Simultaneous push and pop in ONE
        step(1'b1, 1'b1, 16'h0010, 12'h010, 1'b1, 1'b0);
        check("pp_head", 32'(out_data), 32'h0000_0010);
        step(1'b1, 1'b1, 16'h0011, 12'h011, 1'b1, 1'b0);
        check("pp_occ", 32'(occupancy), 32'd1);
        check("pp_next", 32'(out_data), 32'h0000_0011);
        idle(2);

        // Reset while FULL, then a fresh push
        step(1'b1, 1'b1, 16'h00C1, 12'h0C1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'h00C2, 12'h0C2, 1'b0, 1'b0);
        check("pre_rst_occ", 32'(occupancy), 32'd2);
        step(1'b0, 1'b1, 16'h00C3, 12'h0C3, 1'b1, 1'b1);
        check("rst2_occ", 32'(occupancy), 32'd0);
        check("rst2_in_ready", 32'(in_ready), 32'd1);
        check("rst2_out_valid", 32'(out_valid), 32'd0);
        check("rst2_out_data", 32'(out_data), 32'h0000_F000);
        check("rst2_out_ctrl", 32'(out_ctrl), 32'd0);
        step(1'b1, 1'b1, 16'h0020, 12'h020, 1'b1, 1'b0);
        check("post_rst_data", 32'(out_data), 32'h0000_0020);
        check("post_rst_occ", 32'(occupancy), 32'd1);
        idle(3);

        check("b3_never_out", 32'(seen_b3), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
